// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - piece codes, opcodes, command-word fields and the initial board layout
package chess_pkg;

  localparam int SQUARES = 64;
  localparam logic [5:0] LAST_SQ = 6'd63;

  typedef logic [3:0] piece_t;
  localparam piece_t PC_EMPTY  = 4'd0;
  localparam piece_t PC_PAWN   = 4'd1;
  localparam piece_t PC_KNIGHT = 4'd2;
  localparam piece_t PC_BISHOP = 4'd3;
  localparam piece_t PC_ROOK   = 4'd4;
  localparam piece_t PC_QUEEN  = 4'd5;
  localparam piece_t PC_KING   = 4'd6;
  localparam piece_t PC_BLACK  = 4'd8;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_CLEAR    = 3'd1,
    OP_INIT     = 3'd2,
    OP_SET      = 3'd3,
    OP_MOVE     = 3'd4,
    OP_CURSOR   = 3'd5,
    OP_SELECT   = 3'd6,
    OP_DESELECT = 3'd7
  } opcode_t;

  localparam int CMD_TOG    = 31;
  localparam int CMD_OP_HI  = 30;
  localparam int CMD_OP_LO  = 28;
  localparam int CMD_SRC_HI = 27;
  localparam int CMD_SRC_LO = 22;
  localparam int CMD_DST_HI = 21;
  localparam int CMD_DST_LO = 16;
  localparam int CMD_PC_HI  = 15;
  localparam int CMD_PC_LO  = 12;

  // Codes 7 and 15 have no piece type regardless of colour.
  function automatic logic piece_invalid(input piece_t p);
    return p[2:0] == 3'd7;
  endfunction

  function automatic piece_t init_piece(input logic [5:0] sq);
    logic [2:0] rank;
    logic [2:0] file;
    piece_t     back;
    rank = sq[5:3];
    file = sq[2:0];
    case (file)
      3'd0, 3'd7: back = PC_ROOK;
      3'd1, 3'd6: back = PC_KNIGHT;
      3'd2, 3'd5: back = PC_BISHOP;
      3'd3:       back = PC_QUEEN;
      default:    back = PC_KING;
    endcase
    case (rank)
      3'd0:    return back;
      3'd1:    return PC_PAWN;
      3'd6:    return PC_PAWN | PC_BLACK;
      3'd7:    return back | PC_BLACK;
      default: return PC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/chess_board_rf.sv
// rtl/chess_board_rf.sv - 64x4 board register file, two write ports, one peek and one registered read
module chess_board_rf
  import chess_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wa_en,
  input  logic [5:0] i_wa_addr,
  input  piece_t     i_wa_data,
  input  logic       i_wb_en,
  input  logic [5:0] i_wb_addr,
  input  piece_t     i_wb_data,
  input  logic [5:0] i_pk_addr,
  output piece_t     o_pk_data,
  input  logic [5:0] i_rd_addr,
  output piece_t     o_rd_data
);

  piece_t r_board [SQUARES];
  piece_t r_rd_data;

  // Combinational peek feeds the decoder's MOVE source check.
  assign o_pk_data = r_board[i_pk_addr];
  assign o_rd_data = r_rd_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SQUARES; i++) r_board[i] <= PC_EMPTY;
      r_rd_data <= PC_EMPTY;
    end else begin
      r_rd_data <= r_board[i_rd_addr];
      if (i_wa_en) r_board[i_wa_addr] <= i_wa_data;
      if (i_wb_en) r_board[i_wb_addr] <= i_wb_data;
    end
  end

endmodule

// File: rtl/chess_cmd_decoder.sv
// rtl/chess_cmd_decoder.sv - toggle-detected chess command decoder driving the board register file
module chess_cmd_decoder
  import chess_pkg::*;
#(
  parameter int MOVE_CNT_W = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [31:0]           export_data,
  output logic                  ack_toggle,
  output logic                  busy,
  output logic                  err,
  input  logic [5:0]            rd_square,
  output logic [3:0]            rd_piece,
  output logic [5:0]            cursor_sq,
  output logic [5:0]            select_sq,
  output logic                  select_valid,
  output logic [MOVE_CNT_W-1:0] move_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FILL} state_t;

  state_t                r_state;
  logic [31:0]           r_in_q;
  logic [31:0]           r_cmd;
  logic                  r_last_tog;
  logic                  r_ack;
  logic                  r_err;
  logic [5:0]            r_cursor;
  logic [5:0]            r_sel;
  logic                  r_selv;
  logic [MOVE_CNT_W-1:0] r_mc;
  logic [5:0]            r_idx;

  logic       w_tog;
  opcode_t    w_op;
  logic [5:0] w_src;
  logic [5:0] w_dst;
  piece_t     w_pc;
  piece_t     w_src_piece;
  logic       w_reject;
  logic       w_unused_rsvd;
  logic       w_wa_en;
  logic [5:0] w_wa_addr;
  piece_t     w_wa_data;
  logic       w_wb_en;
  logic [5:0] w_wb_addr;

  assign w_tog         = r_cmd[CMD_TOG];
  assign w_op          = opcode_t'(r_cmd[CMD_OP_HI:CMD_OP_LO]);
  assign w_src         = r_cmd[CMD_SRC_HI:CMD_SRC_LO];
  assign w_dst         = r_cmd[CMD_DST_HI:CMD_DST_LO];
  assign w_pc          = r_cmd[CMD_PC_HI:CMD_PC_LO];
  assign w_unused_rsvd = ^r_cmd[11:0];

  assign w_reject = ((w_op == OP_SET) && piece_invalid(w_pc)) ||
                    ((w_op == OP_MOVE) && ((w_src == w_dst) || (w_src_piece == PC_EMPTY)));

  // The EXEC cycle of CLEAR/INIT already writes square 0; FILL covers 1..63.
  always_comb begin
    w_wa_en   = 1'b0;
    w_wa_addr = 6'd0;
    w_wa_data = PC_EMPTY;
    w_wb_en   = 1'b0;
    w_wb_addr = 6'd0;
    if (r_state == ST_EXEC) begin
      case (w_op)
        OP_CLEAR: w_wa_en = 1'b1;
        OP_INIT: begin
          w_wa_en   = 1'b1;
          w_wa_data = init_piece(6'd0);
        end
        OP_SET: begin
          w_wa_en   = !w_reject;
          w_wa_addr = w_dst;
          w_wa_data = w_pc;
        end
        OP_MOVE: begin
          w_wa_en   = !w_reject;
          w_wa_addr = w_dst;
          w_wa_data = w_src_piece;
          w_wb_en   = !w_reject;
          w_wb_addr = w_src;
        end
        default: ;
      endcase
    end else if (r_state == ST_FILL) begin
      w_wa_en   = 1'b1;
      w_wa_addr = r_idx;
      w_wa_data = (w_op == OP_INIT) ? init_piece(r_idx) : PC_EMPTY;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_in_q     <= '0;
      r_cmd      <= '0;
      r_last_tog <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_cursor   <= 6'd0;
      r_sel      <= 6'd0;
      r_selv     <= 1'b0;
      r_mc       <= '0;
      r_idx      <= 6'd0;
    end else begin
      r_in_q <= export_data;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_in_q[CMD_TOG] != r_last_tog) begin
            r_cmd   <= r_in_q;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if ((w_op == OP_CLEAR) || (w_op == OP_INIT)) begin
            r_idx   <= 6'd1;
            r_state <= ST_FILL;
          end else begin
            r_last_tog <= w_tog;
            r_ack      <= w_tog;
            r_state    <= ST_IDLE;
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              case (w_op)
                OP_MOVE: begin
                  r_mc   <= r_mc + 1'b1;
                  r_selv <= 1'b0;
                end
                OP_CURSOR: r_cursor <= w_dst;
                OP_SELECT: begin
                  r_sel  <= w_src;
                  r_selv <= 1'b1;
                end
                OP_DESELECT: r_selv <= 1'b0;
                default: ;
              endcase
            end
          end
        end
        ST_FILL: begin
          if (r_idx == LAST_SQ) begin
            r_last_tog <= w_tog;
            r_ack      <= w_tog;
            r_state    <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  chess_board_rf u_board (
    .i_clk     (Clk),
    .i_rst     (Reset),
    .i_wa_en   (w_wa_en),
    .i_wa_addr (w_wa_addr),
    .i_wa_data (w_wa_data),
    .i_wb_en   (w_wb_en),
    .i_wb_addr (w_wb_addr),
    .i_wb_data (PC_EMPTY),
    .i_pk_addr (w_src),
    .o_pk_data (w_src_piece),
    .i_rd_addr (rd_square),
    .o_rd_data (rd_piece)
  );

  assign ack_toggle   = r_ack;
  assign busy         = (r_state != ST_IDLE);
  assign err          = r_err;
  assign cursor_sq    = r_cursor;
  assign select_sq    = r_sel;
  assign select_valid = r_selv;
  assign move_count   = r_mc;

endmodule

// File: tb/tb_chess_cmd_decoder.sv
// tb/tb_chess_cmd_decoder.sv - scoreboard bench for chess_cmd_decoder against a board-level model
module tb_chess_cmd_decoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] export_data;
  logic        ack_toggle;
  logic        busy;
  logic        err;
  logic [5:0]  rd_square;
  logic [3:0]  rd_piece;
  logic [5:0]  cursor_sq;
  logic [5:0]  select_sq;
  logic        select_valid;
  logic [9:0]  move_count;

  chess_cmd_decoder #(.MOVE_CNT_W(10)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .export_data  (export_data),
    .ack_toggle   (ack_toggle),
    .busy         (busy),
    .err          (err),
    .rd_square    (rd_square),
    .rd_piece     (rd_piece),
    .cursor_sq    (cursor_sq),
    .select_sq    (select_sq),
    .select_valid (select_valid),
    .move_count   (move_count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    bit tog;
    bit er;
    int mc;
    int cur;
    int sel;
    bit selv;
    int issue;
    int lat;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int mb[64];
  bit m_tog;
  int m_mc;
  int m_cur;
  int m_sel;
  bit m_selv;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mb[i]) mb[i] = 0;
    m_tog = 0; m_mc = 0; m_cur = 0; m_sel = 0; m_selv = 0;
  endtask

  task automatic model_init();
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    foreach (mb[i]) mb[i] = 0;
    for (int f = 0; f < 8; f++) begin
      mb[f]      = back[f];
      mb[8 + f]  = 1;
      mb[48 + f] = 9;
      mb[56 + f] = back[f] + 8;
    end
  endtask

  // Monitor: every ack edge retires exactly one expected command.
  bit   prev_ack = 1'b0;
  exp_t e;
  always @(negedge Clk) begin
    if (Reset) begin
      prev_ack = ack_toggle;
    end else begin
      if (ack_toggle != prev_ack) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack %0d with no command outstanding", ack_toggle);
        end else begin
          e = sbq.pop_front();
          check("ack", ack_toggle, e.tog);
          check("err", err, e.er);
          check("busy_at_ack", busy, 0);
          check("move_count", move_count, e.mc);
          check("cursor_sq", cursor_sq, e.cur);
          check("select_sq", select_sq, e.sel);
          check("select_valid", select_valid, e.selv);
          if (e.lat >= 0) check("ack_latency", cyc - e.issue, e.lat);
        end
      end else begin
        check("stray_err", err, 0);
      end
      prev_ack = ack_toggle;
    end
  end

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(posedge Clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic issue(input int op, input int src, input int dst, input int pc, input bit nowait);
    exp_t       x;
    bit         rej;
    logic [2:0] o3;
    logic [5:0] s6;
    logic [5:0] d6;
    logic [3:0] p4;
    if (!nowait) drain();
    @(posedge Clk);
    #1;
    m_tog = ~m_tog;
    o3 = op[2:0]; s6 = src[5:0]; d6 = dst[5:0]; p4 = pc[3:0];
    export_data = {m_tog, o3, s6, d6, p4, 12'($urandom)};
    rej = 0;
    case (op)
      1: foreach (mb[i]) mb[i] = 0;
      2: model_init();
      3: if (pc == 7 || pc == 15) rej = 1; else mb[dst] = pc;
      4: begin
        if (src == dst || mb[src] == 0) rej = 1;
        else begin
          mb[dst] = mb[src];
          mb[src] = 0;
          m_mc    = (m_mc + 1) % 1024;
          m_selv  = 0;
        end
      end
      5: m_cur = dst;
      6: begin m_sel = src; m_selv = 1; end
      7: m_selv = 0;
      default: ;
    endcase
    x.tog = m_tog; x.er = rej; x.mc = m_mc; x.cur = m_cur; x.sel = m_sel; x.selv = m_selv;
    x.issue = cyc;
    x.lat = nowait ? -1 : ((op == 1 || op == 2) ? 66 : 3);
    sbq.push_back(x);
  endtask

  task automatic sweep(input string tag);
    drain();
    for (int sq = 0; sq < 64; sq++) begin
      @(posedge Clk);
      #1 rd_square = sq[5:0];
      @(posedge Clk);
      #1 check($sformatf("%s_sq%0d", tag, sq), rd_piece, mb[sq]);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, src, dst, pc, n;
    Reset = 1'b1;
    export_data = 32'd0;
    rd_square = 6'd0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ack", ack_toggle, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_cursor", cursor_sq, 0);
    check("rst_select", select_sq, 0);
    check("rst_selv", select_valid, 0);
    check("rst_mc", move_count, 0);
    check("rst_rd_piece", rd_piece, 0);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);

    issue(0, 0, 0, 0, 0);
    sweep("nop");

    issue(2, 0, 0, 0, 0);
    repeat (10) @(posedge Clk);
    #1 check("busy_in_fill", busy, 1);
    sweep("init");

    issue(4, 12, 28, 0, 0);
    issue(4, 12, 28, 0, 0);
    issue(3, 0, 20, 7, 0);
    issue(3, 0, 20, 13, 0);
    sweep("moveset");

    issue(2, 0, 0, 0, 0);
    repeat (10) @(posedge Clk);
    issue(5, 0, 33, 0, 1);
    drain();
    repeat (20) @(posedge Clk);
    sweep("busywrite");

    if (m_tog == 0) issue(0, 0, 0, 0, 0);
    drain();
    issue(2, 0, 0, 0, 0);
    repeat (32) @(posedge Clk);
    #1;
    check("busy_before_reset", busy, 1);
    Reset = 1'b1;
    export_data = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    sbq.delete();
    model_reset();
    check("midfill_rst_ack", ack_toggle, 0);
    check("midfill_rst_busy", busy, 0);
    check("midfill_rst_mc", move_count, 0);
    sweep("midfill_rst");

    for (int i = 0; i < 160; i++) begin
      op = $urandom_range(0, 7);
      if ((op == 1 || op == 2) && $urandom_range(0, 2) != 0) op = $urandom_range(3, 4);
      src = $urandom_range(0, 63);
      dst = $urandom_range(0, 63);
      pc = $urandom_range(0, 15);
      if (op == 4 && $urandom_range(0, 3) != 0) begin
        n = 0;
        while (mb[src] == 0 && n < 64) begin
          src = $urandom_range(0, 63);
          n++;
        end
      end
      issue(op, src, dst, pc, 0);
      if (i % 40 == 39) sweep($sformatf("rand%0d", i));
    end

    issue(2, 0, 0, 0, 0);
    n = 1024 - m_mc;
    for (int i = 0; i < n; i++) begin
      if (mb[12] != 0) issue(4, 12, 20, 0, 0);
      else issue(4, 20, 12, 0, 0);
    end
    drain();
    #1 check("mc_wrapped", move_count, 0);
    issue(6, 9, 0, 0, 0);
    if (mb[12] != 0) issue(4, 12, 20, 0, 0);
    else issue(4, 20, 12, 0, 0);
    sweep("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
